// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, combinational I-mem fetch, IF/ID register.
// Stalls hold everything; redirects keep the delay slot; an out-of-window or misaligned PC halts.
module if_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] im_pc,
  input  logic [31:0] im_instr,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc8,
  output logic        id_valid,
  output logic        fetch_err,
  output logic [31:0] err_pc
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  // 33-bit bounds so a window ending exactly at 2^32 still compares correctly.
  localparam logic [32:0] WIN_LO = {1'b0, PC_RESET};
  localparam logic [32:0] WIN_HI = WIN_LO + (33'(IM_WORDS) << 2);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc8_q, id_pc8_d;
  logic        id_valid_q, id_valid_d;
  logic        fetch_err_q, fetch_err_d;
  logic [31:0] err_pc_q, err_pc_d;

  logic [31:0] pc_cand;
  logic        cand_ok;

  always_comb begin
    pc_cand = redirect ? redirect_pc : (pc_q + 32'd4);
    cand_ok = ({1'b0, pc_cand} >= WIN_LO) && ({1'b0, pc_cand} < WIN_HI) &&
              (pc_cand[1:0] == 2'b00);
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    id_instr_d  = id_instr_q;
    id_pc_d     = id_pc_q;
    id_pc8_d    = id_pc8_q;
    id_valid_d  = id_valid_q;
    fetch_err_d = fetch_err_q;
    err_pc_d    = err_pc_q;

    unique case (state_q)
      RUN: begin
        if (!stall) begin
          id_instr_d = im_instr;
          id_pc_d    = pc_q;
          id_pc8_d   = pc_q + 32'd8;
          id_valid_d = 1'b1;
          pc_d       = pc_cand;
          if (!cand_ok) begin
            err_pc_d    = pc_cand;
            fetch_err_d = 1'b1;
            state_d     = HALT;
          end
        end
      end
      HALT: begin
        id_instr_d = '0;
        id_valid_d = 1'b0;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= RUN;
      pc_q        <= PC_RESET;
      id_instr_q  <= '0;
      id_pc_q     <= '0;
      id_pc8_q    <= 32'd8;
      id_valid_q  <= 1'b0;
      fetch_err_q <= 1'b0;
      err_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      id_instr_q  <= id_instr_d;
      id_pc_q     <= id_pc_d;
      id_pc8_q    <= id_pc8_d;
      id_valid_q  <= id_valid_d;
      fetch_err_q <= fetch_err_d;
      err_pc_q    <= err_pc_d;
    end
  end

  assign im_pc     = pc_q;
  assign id_instr  = id_instr_q;
  assign id_pc     = id_pc_q;
  assign id_pc8    = id_pc8_q;
  assign id_valid  = id_valid_q;
  assign fetch_err = fetch_err_q;
  assign err_pc    = err_pc_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a behavioural instruction memory.
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] im_pc;
  logic [31:0] im_instr;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc8;
  logic        id_valid;
  logic        fetch_err;
  logic [31:0] err_pc;

  int unsigned checks = 0;
  int unsigned fails  = 0;

  if_stage #(.PC_RESET(32'h0000_3000), .IM_WORDS(1024)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .im_pc(im_pc), .im_instr(im_instr),
    .id_instr(id_instr), .id_pc(id_pc), .id_pc8(id_pc8), .id_valid(id_valid),
    .fetch_err(fetch_err), .err_pc(err_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h3000: return 32'h1111_1111;
      32'h3004: return 32'h2222_2222;
      32'h3008: return 32'h3333_3333;
      default:  return {16'hC0DE, a[15:0]};
    endcase
  endfunction

  always_comb im_instr = mem_word(im_pc);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    step(); step();
    checks++; if (im_pc !== 32'h3000) begin fails++; $display("FAIL rst_im_pc got %h exp %h", im_pc, 32'h3000); end
    checks++; if (id_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b exp 0", id_valid); end
    checks++; if (id_instr !== 32'h0) begin fails++; $display("FAIL rst_instr got %h exp 0", id_instr); end
    checks++; if (id_pc !== 32'h0) begin fails++; $display("FAIL rst_id_pc got %h exp 0", id_pc); end
    checks++; if (id_pc8 !== 32'h8) begin fails++; $display("FAIL rst_id_pc8 got %h exp 8", id_pc8); end
    checks++; if (fetch_err !== 1'b0 || err_pc !== 32'h0) begin fails++; $display("FAIL rst_err got %b/%h exp 0/0", fetch_err, err_pc); end
    reset = 1'b1;
    step();
    checks++; if (id_instr !== 32'h1111_1111) begin fails++; $display("FAIL seq_instr0 got %h exp 11111111", id_instr); end
    checks++; if (id_pc !== 32'h3000 || id_pc8 !== 32'h3008) begin fails++; $display("FAIL seq_pc0 got %h/%h exp 3000/3008", id_pc, id_pc8); end
    checks++; if (id_valid !== 1'b1) begin fails++; $display("FAIL seq_valid0 got %b exp 1", id_valid); end
    checks++; if (im_pc !== 32'h3004) begin fails++; $display("FAIL seq_im_pc1 got %h exp 3004", im_pc); end
    step();
    checks++; if (id_instr !== 32'h2222_2222 || id_pc !== 32'h3004) begin fails++; $display("FAIL seq_instr1 got %h@%h exp 22222222@3004", id_instr, id_pc); end
    checks++; if (im_pc !== 32'h3008) begin fails++; $display("FAIL seq_im_pc2 got %h exp 3008", im_pc); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (im_pc !== 32'h3008) begin fails++; $display("FAIL stall_im_pc[%0d] got %h exp 3008", i, im_pc); end
      checks++; if (id_instr !== 32'h2222_2222 || id_pc !== 32'h3004) begin fails++; $display("FAIL stall_hold[%0d] got %h@%h exp 22222222@3004", i, id_instr, id_pc); end
    end
    stall = 1'b0;
    step();
    checks++; if (id_instr !== 32'h3333_3333 || id_pc !== 32'h3008) begin fails++; $display("FAIL stall_release got %h@%h exp 33333333@3008", id_instr, id_pc); end
    checks++; if (im_pc !== 32'h300C) begin fails++; $display("FAIL stall_next_pc got %h exp 300c", im_pc); end
  endtask

  task automatic test_branch();
    step();
    checks++; if (id_pc !== 32'h300C || im_pc !== 32'h3010) begin fails++; $display("FAIL br_pre got %h/%h exp 300c/3010", id_pc, im_pc); end
    redirect = 1'b1; redirect_pc = 32'h3040;
    step();
    redirect = 1'b0;
    checks++; if (id_pc !== 32'h3010 || id_instr !== 32'hC0DE_3010) begin fails++; $display("FAIL br_delay_slot got %h@%h exp c0de3010@3010", id_instr, id_pc); end
    checks++; if (im_pc !== 32'h3040) begin fails++; $display("FAIL br_im_pc got %h exp 3040", im_pc); end
    step();
    checks++; if (id_pc !== 32'h3040 || id_instr !== 32'hC0DE_3040 || id_pc8 !== 32'h3048) begin fails++; $display("FAIL br_target got %h@%h pc8 %h exp c0de3040@3040 pc8 3048", id_instr, id_pc, id_pc8); end
  endtask

  task automatic test_redirect_stall();
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h3080;
    step();
    checks++; if (im_pc !== 32'h3044 || id_pc !== 32'h3040) begin fails++; $display("FAIL rs_hold got %h/%h exp 3044/3040", im_pc, id_pc); end
    stall = 1'b0;
    step();
    redirect = 1'b0;
    checks++; if (im_pc !== 32'h3080 || id_pc !== 32'h3044) begin fails++; $display("FAIL rs_redirect got %h/%h exp 3080/3044", im_pc, id_pc); end
    step();
    checks++; if (id_pc !== 32'h3080 || im_pc !== 32'h3084) begin fails++; $display("FAIL rs_target got %h/%h exp 3080/3084", id_pc, im_pc); end
  endtask

  task automatic test_fault_misaligned();
    redirect = 1'b1; redirect_pc = 32'h3002;
    step();
    redirect = 1'b0;
    checks++; if (fetch_err !== 1'b1 || err_pc !== 32'h3002) begin fails++; $display("FAIL mis_err got %b/%h exp 1/3002", fetch_err, err_pc); end
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h3084 || id_instr !== 32'hC0DE_3084) begin fails++; $display("FAIL mis_last got %b %h@%h exp 1 c0de3084@3084", id_valid, id_instr, id_pc); end
    checks++; if (im_pc !== 32'h3002) begin fails++; $display("FAIL mis_im_pc got %h exp 3002", im_pc); end
    step();
    checks++; if (id_valid !== 1'b0 || id_instr !== 32'h0) begin fails++; $display("FAIL halt_nop got %b/%h exp 0/0", id_valid, id_instr); end
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h3100;
    step();
    stall = 1'b0; redirect = 1'b0;
    checks++; if (im_pc !== 32'h3002 || fetch_err !== 1'b1 || err_pc !== 32'h3002 || id_valid !== 1'b0) begin fails++; $display("FAIL halt_sticky got pc %h err %b/%h v %b exp 3002 1/3002 0", im_pc, fetch_err, err_pc, id_valid); end
    reset = 1'b0;
    step();
    reset = 1'b1;
    checks++; if (fetch_err !== 1'b0 || err_pc !== 32'h0 || im_pc !== 32'h3000) begin fails++; $display("FAIL halt_reset got %b/%h pc %h exp 0/0 3000", fetch_err, err_pc, im_pc); end
    step();
    checks++; if (id_instr !== 32'h1111_1111 || id_valid !== 1'b1) begin fails++; $display("FAIL restart got %h v %b exp 11111111 v 1", id_instr, id_valid); end
  endtask

  task automatic test_fault_window();
    redirect = 1'b1; redirect_pc = 32'h4000;
    step();
    redirect = 1'b0;
    checks++; if (fetch_err !== 1'b1 || err_pc !== 32'h4000) begin fails++; $display("FAIL top_err got %b/%h exp 1/4000", fetch_err, err_pc); end
    reset = 1'b0; step(); reset = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h2FFC;
    step();
    redirect = 1'b0;
    checks++; if (fetch_err !== 1'b1 || err_pc !== 32'h2FFC) begin fails++; $display("FAIL below_err got %b/%h exp 1/2ffc", fetch_err, err_pc); end
    reset = 1'b0; step(); reset = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h3FFC;
    step();
    redirect = 1'b0;
    checks++; if (fetch_err !== 1'b0 || im_pc !== 32'h3FFC) begin fails++; $display("FAIL last_word_ok got %b pc %h exp 0 3ffc", fetch_err, im_pc); end
    step();
    checks++; if (fetch_err !== 1'b1 || err_pc !== 32'h4000) begin fails++; $display("FAIL fallthru_err got %b/%h exp 1/4000", fetch_err, err_pc); end
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h3FFC || id_instr !== 32'hC0DE_3FFC) begin fails++; $display("FAIL fallthru_last got %b %h@%h exp 1 c0de3ffc@3ffc", id_valid, id_instr, id_pc); end
  endtask

  task automatic test_reset_in_stall();
    reset = 1'b0; step(); reset = 1'b1;
    step(); step();
    stall = 1'b1; reset = 1'b0;
    step();
    checks++; if (im_pc !== 32'h3000 || id_valid !== 1'b0 || id_pc8 !== 32'h8) begin fails++; $display("FAIL rst_in_stall got %h v %b pc8 %h exp 3000 0 8", im_pc, id_valid, id_pc8); end
    reset = 1'b1; stall = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stall();
    test_branch();
    test_redirect_stall();
    test_fault_misaligned();
    test_fault_window();
    test_reset_in_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
